mcycle_unit: RTL and testbench
==============================

# mcycle_unit

Multi-cycle arithmetic unit directly downstream of the instruction decoder: it consumes the decoder's M_Start and MCOp controls plus the two register-file read operands. It performs an iterative unsigned multiply or an unsigned divide, one bit per cycle. It holds Busy high so the datapath stalls, then presents a double-width result for write-back, which is gated by the decoder's M_W.

## Interface
- WIDTH, 32, operand and result width in bits.

- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- Start  in  1  request from the decoder (M_Start); sampled only in IDLE.
- MCOp  in  2  operation: 01 = multiply, 10 = divide, 00/11 = none.
- Operand1  in  WIDTH  multiplicand or dividend.
- Operand2  in  WIDTH  multiplier or divisor.
- Result1  out  WIDTH  multiply: product[WIDTH-1:0]; divide: quotient.
- Result2  out  WIDTH  multiply: product[2*WIDTH-1:WIDTH]; divide: remainder.
- Busy  out  1  stall request to the datapath.
- Done  out  1  one-cycle pulse; results are valid.

## Operation
- States:
  - IDLE: waiting for an accepted request.
  - COMPUTING: performing iterations.
  - DONE: presenting results.
- Accept condition: state = IDLE, Start = 1 and MCOp in {01, 10}.
  - Start with MCOp = 00 or 11 is ignored: Busy stays 0 and the state does not change.
- On acceptance:
  - Latch Operand1, Operand2 and MCOp.
  - Clear the iteration counter (ceil(log2(WIDTH+1)) bits).
  - Go to COMPUTING.
- Multiply (shift-add, unsigned), on each COMPUTING edge:
  - If the multiplier LSB is 1, add the multiplicand into the upper half of a 2*WIDTH accumulator. Keep the WIDTH+1-bit carry.
  - Shift the accumulator and the multiplier right by 1.
  - After WIDTH iterations the accumulator holds the full unsigned product. There is no overflow.
- Divide (restoring, unsigned), on each COMPUTING edge:
  - Shift {remainder, dividend} left by 1.
  - Compute trial = remainder - divisor at WIDTH+1 bits.
  - If trial is non-negative, the remainder becomes trial and quotient bit 1 is shifted in. Otherwise the remainder is kept and 0 is shifted in.
- Divide by zero follows the natural algorithm result, with no exception: quotient = all ones, remainder = Operand1.
- Transitions:
  - IDLE → COMPUTING on accept.
  - COMPUTING → DONE when the counter reaches WIDTH-1. Result1 and Result2 are registered on that same edge.
  - DONE → IDLE unconditionally.
- Start is ignored in COMPUTING and DONE.
  - The decoder holds M_Start high for the whole stalled instruction, including the DONE cycle.
  - DONE therefore blocks a re-trigger.
- Operand or MCOp changes after acceptance have no effect.
- Result1 and Result2 hold their value until the next operation completes. They do not change during COMPUTING.

## Timing
- Reset: state = IDLE, counter = 0, Result1 = 0, Result2 = 0, Busy = 0, Done = 0. All internal accumulators are cleared.
- Busy is combinational: Busy = (IDLE and accept condition) or COMPUTING.
  - Busy rises in the same cycle Start is presented, so the pipeline stalls immediately.
- Done = (state == DONE), registered-state decode. Busy is 0 in the DONE cycle.
- Cycle-level sequence for an accept in cycle T:
  - Busy is high in cycles T through T+WIDTH, i.e. WIDTH+1 cycles.
  - Done is high and results are valid in cycle T+WIDTH+1.
  - The state is IDLE in cycle T+WIDTH+2.
  - With WIDTH = 32: Busy for 33 cycles, Done in T+33.
- Back-to-back operations: a new Start in cycle T+WIDTH+2 (the next instruction after the PC advances) is accepted normally.
- RESET asserted in any state, including mid-COMPUTING: on the next edge the unit returns to the reset values and the partial result is discarded. RESET has priority over Start.

## Test plan
- Multiply 7 × 6: Result1 = 42 and Result2 = 0. Busy is high for exactly 33 cycles, Done pulses once, and the results persist after Done.
- Multiply 0xFFFFFFFF × 0xFFFFFFFF: Result1 = 0x00000001 and Result2 = 0xFFFFFFFE. Then 0x80000000 × 2: Result1 = 0 and Result2 = 1.
- Divide 100 / 7: Result1 = 14 and Result2 = 2. Then 5 / 9: Result1 = 0 and Result2 = 5. Then divide 0x12345678 by 0: Result1 = 0xFFFFFFFF and Result2 = 0x12345678.
- Start = 1 with MCOp = 01, held through DONE and for 1 more cycle, with Operand1/Operand2 changed mid-operation:
  - exactly one operation runs on the originally latched operands;
  - the operation restarts only in the cycle after DONE.
- Start = 1 with MCOp = 00 or 11 for 5 cycles: Busy and Done stay 0 and the results are unchanged.
- RESET pulsed 10 cycles into a divide: all outputs return to 0 and no Done occurs. A following multiply 3 × 5 then completes with Result1 = 15.

Source files
------------

// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// Ports: CLK, RESET (sync, active-high), Start/MCOp request from decoder, Operand1/Operand2 in;
//        Result1/Result2 double-width result, Busy (combinational stall), Done (one-cycle pulse).
// Latency: Busy for WIDTH+1 cycles from the accept cycle, Done in the cycle after; Start ignored while busy/done.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPUTING = 2'd1,
    DONE      = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      count;
  logic               is_div;
  logic [WIDTH-1:0]   opa;      // multiplicand (multiply only)
  logic [WIDTH-1:0]   opb;      // multiplier (shifts right) or divisor (static)
  // Multiply: {upper partial sum, product bits shifted out}.
  // Divide:   {remainder, dividend bits being replaced by quotient bits}.
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic               accept, last_iter;

  assign accept    = (state == IDLE) && Start && (MCOp == 2'b01 || MCOp == 2'b10);
  assign last_iter = (count == CW'(WIDTH - 1));
  assign Busy      = accept || (state == COMPUTING);
  assign Done      = (state == DONE);

  // One iteration of the selected algorithm.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opb[0] ? {1'b0, opa} : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    // remainder < divisor, so the shifted remainder is < 2*divisor and the
    // WIDTH+1-bit difference carries a valid sign in its MSB.
    div_trial = div_shift - {1'b0, opb};
    acc_nxt   = acc;
    if (is_div) begin
      if (!div_trial[WIDTH]) acc_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                   acc_nxt = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      // Carry of the add becomes the top bit after the right shift.
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = COMPUTING;
      COMPUTING: if (last_iter) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      count   <= '0;
      is_div  <= 1'b0;
      opa     <= '0;
      opb     <= '0;
      acc     <= '0;
      Result1 <= '0;
      Result2 <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            is_div <= (MCOp == 2'b10);
            opa    <= Operand1;
            opb    <= Operand2;
            acc    <= (MCOp == 2'b10) ? {{WIDTH{1'b0}}, Operand1} : '0;
            count  <= '0;
          end
        end
        COMPUTING: begin
          acc   <= acc_nxt;
          count <= count + CW'(1);
          if (!is_div) opb <= opb >> 1;
          if (last_iter) begin
            Result1 <= acc_nxt[WIDTH-1:0];
            Result2 <= acc_nxt[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: randomized and directed stimulus for mcycle_unit against an arithmetic reference model.
// Ports: none (top-level bench); drives the DUT on the falling edge and samples 1 time unit later.
// Latency: each operation is bounded by a 100-cycle budget; an expired budget counts as a failure.
module tb_mcycle_unit;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         Start;
  logic [1:0]   MCOp;
  logic [W-1:0] Operand1, Operand2;
  logic [W-1:0] Result1, Result2;
  logic         Busy, Done;

  int checks   = 0;
  int failures = 0;

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .MCOp(MCOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {Result2, Result1} from plain arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] r;
    if (op == 2'b01) r = 64'(a) * 64'(b);
    else if (b == 0) r = {a, 32'hFFFF_FFFF};
    else             r = {a % b, a / b};
    return r;
  endfunction

  task automatic start_cycle(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    Start = 1'b1; MCOp = op; Operand1 = a; Operand2 = b;
    #1;
  endtask

  // Runs from the accept cycle (already applied) until Done, scrambling inputs
  // while Start stays high, and returns in the Done cycle.
  task automatic finish_op(input string tag, input logic [63:0] exp);
    int busy_n = 0;
    int cyc = 0;
    bit held = 1'b1;
    logic [63:0] prev = {Result2, Result1};
    while (!Done && cyc < 100) begin
      if (Busy) busy_n++;
      if ({Result2, Result1} !== prev) held = 1'b0;
      cyc++;
      @(negedge CLK);
      Operand1 = $urandom; Operand2 = $urandom; MCOp = 2'($urandom_range(0, 3));
      #1;
    end
    check({tag, "_done_seen"}, 64'(Done), 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(W + 1));
    check({tag, "_result_stable"}, 64'(held), 64'd1);
    check({tag, "_busy_in_done"}, 64'(Busy), 64'd0);
    check({tag, "_result"}, {Result2, Result1}, exp);
  endtask

  task automatic idle_after(input string tag, input logic [63:0] exp);
    @(negedge CLK);
    Start = 1'b0; MCOp = 2'b00;
    #1;
    check({tag, "_done_once"}, 64'(Done), 64'd0);
    check({tag, "_idle_busy"}, 64'(Busy), 64'd0);
    check({tag, "_persist"}, {Result2, Result1}, exp);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] exp = model(op, a, b);
    start_cycle(op, a, b);
    finish_op(tag, exp);
    idle_after(tag, exp);
  endtask

  initial begin
    logic [63:0] last;
    logic [1:0]  op;
    logic [W-1:0] a, b;
    bit quiet;
    bit no_done;

    RESET = 1'b1; Start = 1'b0; MCOp = 2'b00; Operand1 = '0; Operand2 = '0;
    repeat (3) @(negedge CLK);
    #1;
    check("reset_results", {Result2, Result1}, 64'd0);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    @(negedge CLK);
    RESET = 1'b0;

    // Directed cases.
    run_op("mul_7x6", 2'b01, 32'd7, 32'd6);
    run_op("mul_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul_msb", 2'b01, 32'h8000_0000, 32'd2);
    run_op("div_100_7", 2'b10, 32'd100, 32'd7);
    run_op("div_5_9", 2'b10, 32'd5, 32'd9);
    run_op("div_by_0", 2'b10, 32'h1234_5678, 32'd0);

    // Start held through DONE and one cycle beyond: exactly one op on the
    // latched operands, then a restart accepted only in the cycle after DONE.
    start_cycle(2'b01, 32'd1000, 32'd3);
    finish_op("held_first", model(2'b01, 32'd1000, 32'd3));
    start_cycle(2'b01, 32'd11, 32'd13);
    check("held_restart_busy", 64'(Busy), 64'd1);
    finish_op("held_second", model(2'b01, 32'd11, 32'd13));
    idle_after("held_second", model(2'b01, 32'd11, 32'd13));

    // Invalid MCOp codes are ignored.
    last = {Result2, Result1};
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      Start = 1'b1; MCOp = (i % 2 == 0) ? 2'b00 : 2'b11;
      Operand1 = $urandom; Operand2 = $urandom;
      #1;
      if (Busy || Done || ({Result2, Result1} !== last)) quiet = 1'b0;
    end
    check("invalid_op_quiet", 64'(quiet), 64'd1);
    @(negedge CLK); Start = 1'b0; #1;
    check("invalid_op_idle", 64'(Busy), 64'd0);

    // Reset 10 cycles into a divide.
    start_cycle(2'b10, 32'hDEAD_BEEF, 32'd17);
    repeat (10) begin @(negedge CLK); #1; end
    check("pre_reset_busy", 64'(Busy), 64'd1);
    @(negedge CLK); Start = 1'b0; RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0; #1;
    check("post_reset_results", {Result2, Result1}, 64'd0);
    check("post_reset_busy", 64'(Busy), 64'd0);
    no_done = 1'b1;
    repeat (40) begin
      @(negedge CLK); #1;
      if (Done || Busy) no_done = 1'b0;
    end
    check("post_reset_no_done", 64'(no_done), 64'd1);
    run_op("mul_3x5", 2'b01, 32'd3, 32'd5);

    // Randomized operations, back-to-back with the single idle cycle.
    for (int i = 0; i < 20; i++) begin
      op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 15));
        1:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), op, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
